// File: rtl/fft_window_loader.sv
// fft_window_loader: applies Hann weighting to a real sample stream and loads
// the FFT working RAM in bit-reversed order. Once a full frame is written it
// pulses fft_start, then holds off new samples until the FFT reports done.
module fft_window_loader #(
    parameter int unsigned width = 16,
    parameter int unsigned N_2   = 11,
    parameter int unsigned N     = 2048
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [width-1:0]     sample,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic [N_2-1:0]       hann_idx,
    input  logic [width-1:0]     hann_coef,
    output logic                 we,
    output logic [N_2-1:0]       wadr,
    output logic [2*width-1:0]   wd,
    output logic                 fft_start,
    input  logic                 fft_done,
    output logic                 overrun
);

    localparam int unsigned   prod_w   = 2 * width + 1;
    localparam int unsigned   shift    = width + 5;
    localparam logic [N_2-1:0] last_idx = N_2'(N - 1);

    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                   state;
    logic [N_2-1:0]           count;
    logic                     take;

    logic                     s1_valid;
    logic [width-1:0]         s1_sample;
    logic [N_2-1:0]           s1_idx;
    logic                     s2_last;

    logic signed [prod_w-1:0] prod;
    logic [N_2-1:0]           rev_idx;

    // Ready follows the FSM state and is forced low while reset is asserted.
    assign sample_ready = (state == FILL) && !reset;
    assign take         = sample_valid && sample_ready;

    // The LUT address is the running sample count so the coefficient lines up with stage 1.
    assign hann_idx = count;

    // Signed sample times unsigned coefficient, widened before the multiply.
    assign prod = prod_w'($signed(s1_sample)) * prod_w'($signed({1'b0, hann_coef}));

    // Bit-reversed write address from the stage-1 sample index.
    always_comb begin
        rev_idx = '0;
        for (int i = 0; i < N_2; i++) begin
            rev_idx[i] = s1_idx[N_2-1-i];
        end
    end

    // FSM, two-stage write pipeline and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            count     <= '0;
            s1_valid  <= 1'b0;
            s1_sample <= '0;
            s1_idx    <= '0;
            s2_last   <= 1'b0;
            we        <= 1'b0;
            wadr      <= '0;
            wd        <= '0;
            fft_start <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            s1_valid <= take;
            if (take) begin
                s1_sample <= sample;
                s1_idx    <= count;
            end

            we      <= s1_valid;
            s2_last <= s1_valid && (s1_idx == last_idx);
            if (s1_valid) begin
                wadr <= rev_idx;
                wd   <= {width'(prod >>> shift), width'(0)};
            end

            fft_start <= s2_last;

            if (sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end

            case (state)
                FILL: begin
                    if (take) begin
                        count <= count + N_2'(1);
                        if (count == last_idx) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (fft_done) begin
                        state <= FILL;
                        count <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_window_loader.sv
// Bench for fft_window_loader (width=16, 8-point frame): directed table,
// hand-written corner sequences and random traffic against a reference model.
module tb_fft_window_loader;

    localparam int unsigned W  = 16;
    localparam int unsigned NB = 3;
    localparam int unsigned NP = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [W-1:0]    sample;
    logic            sample_valid;
    logic            sample_ready;
    logic [NB-1:0]   hann_idx;
    logic [W-1:0]    hann_coef = '0;
    logic            we;
    logic [NB-1:0]   wadr;
    logic [2*W-1:0]  wd;
    logic            fft_start;
    logic            fft_done;
    logic            overrun;

    int errors = 0;
    int checks = 0;

    fft_window_loader #(.width(W), .N_2(NB), .N(NP)) dut (
        .clk(clk), .reset(reset), .sample(sample), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .hann_idx(hann_idx), .hann_coef(hann_coef),
        .we(we), .wadr(wadr), .wd(wd), .fft_start(fft_start),
        .fft_done(fft_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Hann ROM stand-in: registered read, contents set by the stimulus.
    logic [W-1:0] coef_tab [NP];
    always @(posedge clk) hann_coef <= coef_tab[hann_idx];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NB-1:0] brev(input int i);
        logic [31:0] v;
        logic [NB-1:0] r;
        v = i;
        r = '0;
        for (int b = 0; b < NB; b++) r[b] = v[NB-1-b];
        return r;
    endfunction

    // floor(sample * coef / 2^(W+5)) with plain integer division
    function automatic logic [W-1:0] scale(input logic [W-1:0] s, input logic [W-1:0] c);
        longint p, d, q;
        p = longint'($signed(s)) * longint'(c);
        d = longint'(1) << (W + 5);
        q = p / d;
        if (p < 0 && q * d != p) q = q - 1;
        return W'(q);
    endfunction

    // Reference model: frame bookkeeping plus scheduled write / start events
    typedef struct {
        longint unsigned due;
        logic [NB-1:0]   adr;
        logic [W-1:0]    re;
    } wr_t;

    longint unsigned ec = 0;
    bit              m_fill = 1'b0;
    int              m_count = 0;
    bit              m_ovr = 1'b0;
    wr_t             wq[$];
    longint unsigned sq[$];

    always @(posedge clk) begin
        ec++;
        if (reset) begin
            m_fill = 1'b1; m_count = 0; m_ovr = 1'b0;
            wq.delete(); sq.delete();
        end else if (m_fill) begin
            if (sample_valid) begin
                wq.push_back('{ec + 1, brev(m_count), scale(sample, coef_tab[m_count])});
                if (m_count == NP - 1) begin
                    sq.push_back(ec + 2);
                    m_fill = 1'b0;
                end
                m_count = (m_count + 1) % NP;
            end
        end else begin
            if (sample_valid) m_ovr = 1'b1;
            if (fft_done) begin
                m_fill = 1'b1; m_count = 0;
            end
        end
    end

    logic [NB-1:0]  cap_adr[$];
    logic [2*W-1:0] cap_wd [NP];

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit exp_we, exp_st;
        logic [NB-1:0] ea;
        logic [W-1:0] er;
        exp_we = 1'b0; exp_st = 1'b0; ea = '0; er = '0;
        if (wq.size() > 0 && wq[0].due == ec) begin
            exp_we = 1'b1; ea = wq[0].adr; er = wq[0].re;
            void'(wq.pop_front());
        end
        if (sq.size() > 0 && sq[0] == ec) begin
            exp_st = 1'b1;
            void'(sq.pop_front());
        end
        chk("sample_ready", 64'(sample_ready), 64'(m_fill && !reset));
        chk("overrun", 64'(overrun), 64'(m_ovr));
        chk("hann_idx", 64'(hann_idx), 64'(m_count));
        chk("we", 64'(we), 64'(exp_we));
        chk("fft_start", 64'(fft_start), 64'(exp_st));
        if (exp_we) begin
            chk("wadr", 64'(wadr), 64'(ea));
            chk("wd", 64'(wd), 64'({er, 16'h0000}));
        end
        if (we === 1'b1) begin
            cap_adr.push_back(wadr);
            cap_wd[wadr] = wd;
        end
    end

    task automatic step(input bit v, input logic [W-1:0] s, input bit d, input bit r);
        @(posedge clk);
        #2;
        sample_valid = v; sample = s; fft_done = d; reset = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    int ord [NP] = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic check_order(input string name);
        logic [NB-1:0] a;
        chk({name, "_len"}, 64'(cap_adr.size()), 64'(NP));
        for (int i = 0; i < NP; i++) begin
            a = (i < cap_adr.size()) ? cap_adr[i] : 'x;
            chk(name, 64'(a), 64'(ord[i]));
        end
    endtask

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic [W-1:0] re;
    } vec_t;
    vec_t tab [NP];

    initial begin
        tab = '{
            '{16'h7FFF, 16'hFFFF, 16'h03FF},
            '{16'h8000, 16'hFFFF, 16'hFC00},
            '{16'hFFFF, 16'h0001, 16'hFFFF},
            '{16'h1234, 16'h0000, 16'h0000},
            '{16'h8000, 16'h0000, 16'h0000},
            '{16'h4000, 16'h8000, 16'h0100},
            '{16'hC000, 16'h8000, 16'hFF00},
            '{16'h0001, 16'hFFFF, 16'h0000}
        };
        for (int i = 0; i < NP; i++) coef_tab[i] = tab[i].c;
        reset = 1'b1; sample_valid = 1'b0; sample = '0; fft_done = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_wadr", 64'(wadr), 64'(0));
        chk("rst_wd", 64'(wd), 64'(0));

        // scaling table over one frame, plus bit-reversed order
        cap_adr.delete();
        for (int i = 0; i < NP; i++) step(1'b1, tab[i].s, 1'b0, 1'b0);
        idle(4);
        for (int i = 0; i < NP; i++)
            chk("scale_wd", 64'(cap_wd[brev(i)]), 64'({tab[i].re, 16'h0000}));
        check_order("order_burst");

        // hold-off with valid held high, then release
        cap_adr.delete();
        for (int i = 0; i < 5; i++) step(1'b1, 16'(i + 100), 1'b0, 1'b0);
        chk("holdoff_no_we", 64'(cap_adr.size()), 64'(0));
        step(1'b0, '0, 1'b1, 1'b0);

        // bubbles: alternate valid
        cap_adr.delete();
        for (int i = 0; i < NP; i++) begin
            step(1'b1, 16'($urandom), 1'b0, 1'b0);
            step(1'b0, 16'($urandom), 1'b0, 1'b0);
        end
        idle(3);
        check_order("order_bubble");
        step(1'b0, '0, 1'b1, 1'b0);

        // reset mid-frame, then a fresh frame
        for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        cap_adr.delete();
        for (int i = 0; i < NP; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        idle(4);
        check_order("order_after_rst");
        chk("overrun_after_rst", 64'(overrun), 64'(0));
        step(1'b0, '0, 1'b1, 1'b0);

        // fft_done during FILL (count=3) and on the final transfer edge are ignored
        cap_adr.delete();
        for (int i = 0; i < NP; i++)
            step(1'b1, 16'($urandom), (i == 3 || i == NP - 1), 1'b0);
        idle(4);
        check_order("order_done_in_fill");
        chk("still_waiting", 64'(sample_ready), 64'(0));
        step(1'b0, '0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            coef_tab[$urandom_range(0, NP - 1)] = 16'($urandom);
            step($urandom_range(0, 3) != 0, 16'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
